fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/fifo_wr_arbiter_rr_picker.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the fifo write-port arbiter.
// The optional per-producer beat counters are enabled by FIFO_WR_ARBITER_STATS_EN.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_WIDTH     = 16;
    localparam int DEF_MAX_BURST = 4;
    localparam int STAT_W        = 16;

    // Index width that stays legal for a single-producer build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin search: first set bit of valid_i at or after ptr_i,
// wrapping from the top producer back to producer 0.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] pick_o,
    output logic [IDX_W-1:0] idx_o
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    always_comb begin
        pick_o   = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!found && valid_i[cand_idx]) begin
                found           = 1'b1;
                pick_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter letting N_REQ producers share one fifo write port in
// bursts of up to MAX_BURST beats. Optional stats: FIFO_WR_ARBITER_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*WIDTH-1:0]   req_data_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic                     fifo_full_i,
    output logic                     fifo_write_en_o,
    output logic [WIDTH-1:0]         fifo_data_o,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     busy_o
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    output logic [N_REQ*STAT_W-1:0]  beat_count_o
`endif
);

    localparam int               IDX_W     = idx_width(N_REQ);
    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] BURST_END = CNT_W'(MAX_BURST);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [N_REQ-1:0] pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             in_grant;
    logic             owner_valid;
    logic             accept;
    logic             burst_done;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .valid_i (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .pick_o  (pick),
        .idx_o   (pick_idx)
    );

    assign pick_any = |pick;

    // Reset gates the outputs directly so they drop in the same cycle it rises.
    assign in_grant    = (state_q == GRANT) && !reset_i;
    assign owner_valid = req_valid_i[owner_q];
    assign accept      = in_grant && owner_valid && !fifo_full_i;
    assign burst_done  = accept && ((beat_cnt_q + 1'b1) == BURST_END);

    always_comb begin
        fifo_write_en_o      = accept;
        req_ready_o          = '0;
        req_ready_o[owner_q] = accept;
        grant_o              = '0;
        grant_o[owner_q]     = in_grant;
        busy_o               = in_grant;
        fifo_data_o          = in_grant ? req_data_i[owner_q*WIDTH +: WIDTH] : '0;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = GRANT;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                // A dropped valid ends the burst even while the fifo is full.
                if (!owner_valid || burst_done) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [N_REQ*STAT_W-1:0] stat_q, stat_d;

    // Per-producer accepted-beat counters, saturating at all-ones.
    always_comb begin
        stat_d = stat_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (req_ready_o[k] && (stat_q[k*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
                stat_d[k*STAT_W +: STAT_W] = stat_q[k*STAT_W +: STAT_W] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign beat_count_o = stat_q;
`endif

    a_no_write_when_full: assert property (
        @(posedge clk_i) disable iff (reset_i) !(fifo_write_en_o && fifo_full_i)
    );

    a_grant_onehot: assert property (
        @(posedge clk_i) disable iff (reset_i) $onehot0(grant_o)
    );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a
// randomized run, all compared against a transaction-level arbitration model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MB = 4;

    logic           clk         = 1'b0;
    logic           reset_i     = 1'b0;
    logic [N-1:0]   req_valid_i = '0;
    logic [N*W-1:0] req_data_i  = '0;
    logic           fifo_full_i = 1'b0;
    logic [N-1:0]   req_ready_o;
    logic           fifo_write_en_o;
    logic [W-1:0]   fifo_data_o;
    logic [N-1:0]   grant_o;
    logic           busy_o;
`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [N*16-1:0] beat_count_o;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Model: who owns the port (-1 = nobody), beats taken, where the search starts.
    int m_owner = -1;
    int m_beats = 0;
    int m_ptr   = 0;
    bit pending = 1'b0;

    logic         e_we;
    logic         e_busy;
    logic [N-1:0] e_ready;
    logic [N-1:0] e_grant;
    logic [W-1:0] e_data;

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .WIDTH     (W),
        .MAX_BURST (MB)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .req_valid_i     (req_valid_i),
        .req_data_i      (req_data_i),
        .req_ready_o     (req_ready_o),
        .fifo_full_i     (fifo_full_i),
        .fifo_write_en_o (fifo_write_en_o),
        .fifo_data_o     (fifo_data_o),
        .grant_o         (grant_o),
        .busy_o          (busy_o)
`ifdef FIFO_WR_ARBITER_STATS_EN
        ,
        .beat_count_o    (beat_count_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'($urandom);
        return r;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_beats = 0;
        m_ptr   = 0;
    endfunction

    // One clock edge of arbitration, from the rules: pick, count beats, hand over.
    function automatic void model_advance(input logic [N-1:0] v, input logic full);
        if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                int c = (m_ptr + i) % N;
                if (v[c]) begin
                    m_owner = c;
                    m_beats = 0;
                    break;
                end
            end
        end else if (!v[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_beats = 0;
        end else if (!full) begin
            m_beats = m_beats + 1;
            if (m_beats == MB) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_beats = 0;
            end
        end
    endfunction

    function automatic void model_eval();
        e_we    = 1'b0;
        e_busy  = 1'b0;
        e_ready = '0;
        e_grant = '0;
        e_data  = '0;
        if (!reset_i && m_owner >= 0) begin
            e_busy           = 1'b1;
            e_grant[m_owner] = 1'b1;
            e_data           = req_data_i[m_owner*W +: W];
            e_we             = req_valid_i[m_owner] && !fifo_full_i;
            e_ready[m_owner] = e_we;
        end
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic full, input logic [N*W-1:0] d);
        @(negedge clk);
        if (pending) model_advance(req_valid_i, fifo_full_i);
        pending     = 1'b1;
        req_valid_i = v;
        fifo_full_i = full;
        req_data_i  = d;
        #1;
        model_eval();
    endtask

    task automatic do_reset(input logic [N-1:0] v);
        @(negedge clk);
        reset_i     = 1'b1;
        req_valid_i = v;
        fifo_full_i = 1'b0;
        req_data_i  = rand_data();
        model_reset();
        pending = 1'b0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        pending = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_i     = 1'b1;
        req_valid_i = '1;
        fifo_full_i = 1'b0;
        req_data_i  = rand_data();
        model_reset();
        pending = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if ({fifo_write_en_o, req_ready_o, grant_o, busy_o, fifo_data_o} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs c%0d: we=%b rdy=%b gnt=%b busy=%b data=%h, required all zero",
                         c, fifo_write_en_o, req_ready_o, grant_o, busy_o, fifo_data_o);
            end
            @(negedge clk);
        end
        reset_i = 1'b0;
        pending = 1'b1;
        drive('1, 1'b0, rand_data());
        vectors++;
        if (grant_o !== 4'b0001 || grant_o !== e_grant) begin
            miscompares++;
            $display("FAIL reset_first_grant: grant=%b, required 0001 (model %b)", grant_o, e_grant);
        end
    endtask

    task automatic test_single_stream();
        logic [W-1:0] words [6];
        logic [11:0]  we_hist;
        int tx;
        int rx;
        words = '{16'hbeef, 16'hceef, 16'hdeef, 16'heeef, 16'hfeef, 16'h0eef};
        tx = 0;
        rx = 0;
        we_hist = '0;
        do_reset('0);
        for (int c = 0; c < 12; c++) begin
            logic [N*W-1:0] d;
            d = rand_data();
            if (tx < 6) d[W-1:0] = words[tx];
            drive((tx < 6) ? 4'b0001 : 4'b0000, 1'b0, d);
            vectors++;
            if ({fifo_write_en_o, req_ready_o, grant_o, busy_o, fifo_data_o} !== {e_we, e_ready, e_grant, e_busy, e_data}) begin
                miscompares++;
                $display("FAIL stream c%0d: we=%b rdy=%b gnt=%b busy=%b data=%h, required we=%b rdy=%b gnt=%b busy=%b data=%h",
                         c, fifo_write_en_o, req_ready_o, grant_o, busy_o, fifo_data_o, e_we, e_ready, e_grant, e_busy, e_data);
            end
            we_hist[c] = fifo_write_en_o;
            if (fifo_write_en_o === 1'b1) begin
                vectors++;
                if (rx >= 6 || fifo_data_o !== words[rx]) begin
                    miscompares++;
                    $display("FAIL stream_word%0d: got %h, required %h", rx, fifo_data_o, (rx < 6) ? words[rx] : 16'h0);
                end
                rx++;
            end
            if (req_ready_o[0] === 1'b1) tx++;
        end
        vectors++;
        if (we_hist !== 12'h0DE || rx != 6) begin
            miscompares++;
            $display("FAIL stream_pattern: write pattern %b count %0d, required 000011011110 count 6", we_hist, rx);
        end
    endtask

    task automatic test_all_valid();
        logic [N-1:0] exp_g [5];
        logic [N-1:0] gseq [$];
        int           wcnt [$];
        logic         prev_busy;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        prev_busy = 1'b0;
        do_reset('1);
        for (int c = 0; c < 25; c++) begin
            drive('1, 1'b0, rand_data());
            vectors++;
            if ({fifo_write_en_o, req_ready_o, grant_o, busy_o, fifo_data_o} !== {e_we, e_ready, e_grant, e_busy, e_data}) begin
                miscompares++;
                $display("FAIL allvalid c%0d: we=%b rdy=%b gnt=%b busy=%b data=%h, required we=%b rdy=%b gnt=%b busy=%b data=%h",
                         c, fifo_write_en_o, req_ready_o, grant_o, busy_o, fifo_data_o, e_we, e_ready, e_grant, e_busy, e_data);
            end
            if (busy_o === 1'b1 && prev_busy !== 1'b1) begin
                gseq.push_back(grant_o);
                wcnt.push_back(0);
            end
            if (fifo_write_en_o === 1'b1 && wcnt.size() > 0) wcnt[wcnt.size()-1]++;
            prev_busy = busy_o;
        end
        vectors++;
        if (gseq.size() < 5) begin
            miscompares++;
            $display("FAIL allvalid_grants: saw %0d grants, required at least 5", gseq.size());
        end else begin
            for (int g = 0; g < 5; g++) begin
                vectors++;
                if (gseq[g] !== exp_g[g] || wcnt[g] != MB) begin
                    miscompares++;
                    $display("FAIL allvalid_grant%0d: grant=%b writes=%0d, required grant=%b writes=%0d",
                             g, gseq[g], wcnt[g], exp_g[g], MB);
                end
            end
        end
    endtask

    task automatic test_full_stall();
        int writes;
        writes = 0;
        do_reset(4'b0001);
        for (int c = 0; c < 8; c++) begin
            drive(4'b0001, (c >= 2 && c <= 4), rand_data());
            vectors++;
            if ({fifo_write_en_o, req_ready_o, grant_o, busy_o, fifo_data_o} !== {e_we, e_ready, e_grant, e_busy, e_data}) begin
                miscompares++;
                $display("FAIL stall c%0d: we=%b rdy=%b gnt=%b busy=%b, required we=%b rdy=%b gnt=%b busy=%b",
                         c, fifo_write_en_o, req_ready_o, grant_o, busy_o, e_we, e_ready, e_grant, e_busy);
            end
            if (c >= 2 && c <= 4) begin
                vectors++;
                if (fifo_write_en_o !== 1'b0 || req_ready_o !== '0 || busy_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall_full c%0d: we=%b rdy=%b busy=%b, required we=0 rdy=0000 busy=1",
                             c, fifo_write_en_o, req_ready_o, busy_o);
                end
            end
            if (c < 7 && fifo_write_en_o === 1'b1) writes++;
            if (c == 7) begin
                vectors++;
                if (writes != 4 || busy_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_total: writes=%0d busy=%b, required writes=4 busy=0", writes, busy_o);
                end
            end
        end
    endtask

    task automatic test_owner_drop();
        logic [N-1:0] vseq [5];
        vseq = '{4'b0110, 4'b0110, 4'b0100, 4'b0100, 4'b0100};
        do_reset(4'b0010);
        for (int c = 0; c < 5; c++) begin
            drive(vseq[c], 1'b0, rand_data());
            vectors++;
            if ({fifo_write_en_o, req_ready_o, grant_o, busy_o, fifo_data_o} !== {e_we, e_ready, e_grant, e_busy, e_data}) begin
                miscompares++;
                $display("FAIL drop c%0d: we=%b rdy=%b gnt=%b busy=%b, required we=%b rdy=%b gnt=%b busy=%b",
                         c, fifo_write_en_o, req_ready_o, grant_o, busy_o, e_we, e_ready, e_grant, e_busy);
            end
            if (c == 3) begin
                vectors++;
                if (busy_o !== 1'b0 || grant_o !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL drop_idle: busy=%b grant=%b, required busy=0 grant=0000", busy_o, grant_o);
                end
            end
            if (c == 4) begin
                vectors++;
                if (grant_o !== 4'b0100) begin
                    miscompares++;
                    $display("FAIL drop_regrant: grant=%b, required 0100", grant_o);
                end
            end
        end
    endtask

    task automatic test_reset_midburst();
        do_reset(4'b1000);
        for (int c = 0; c < 3; c++) begin
            drive(4'b1000, 1'b0, rand_data());
            vectors++;
            if (fifo_write_en_o !== e_we || grant_o !== 4'b1000) begin
                miscompares++;
                $display("FAIL midburst_beat%0d: we=%b grant=%b, required we=%b grant=1000", c + 1, fifo_write_en_o, grant_o, e_we);
            end
        end
        reset_i = 1'b1;
        #1;
        vectors++;
        if ({fifo_write_en_o, req_ready_o, grant_o, busy_o, fifo_data_o} !== '0) begin
            miscompares++;
            $display("FAIL midburst_reset: we=%b rdy=%b gnt=%b busy=%b data=%h, required all zero",
                     fifo_write_en_o, req_ready_o, grant_o, busy_o, fifo_data_o);
        end
        model_reset();
        pending = 1'b0;
        @(negedge clk);
        req_valid_i = '1;
        @(negedge clk);
        reset_i = 1'b0;
        pending = 1'b1;
        drive('1, 1'b0, rand_data());
        vectors++;
        if (grant_o !== 4'b0001 || fifo_write_en_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midburst_restart: grant=%b we=%b, required grant=0001 we=1", grant_o, fifo_write_en_o);
        end
    endtask

    task automatic test_random();
        do_reset('0);
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] v;
            for (int k = 0; k < N; k++) v[k] = ($urandom_range(0, 9) < 7);
            drive(v, ($urandom_range(0, 4) == 0), rand_data());
            vectors++;
            if ({fifo_write_en_o, req_ready_o, grant_o, busy_o, fifo_data_o} !== {e_we, e_ready, e_grant, e_busy, e_data}) begin
                miscompares++;
                $display("FAIL random c%0d: we=%b rdy=%b gnt=%b busy=%b data=%h, required we=%b rdy=%b gnt=%b busy=%b data=%h",
                         c, fifo_write_en_o, req_ready_o, grant_o, busy_o, fifo_data_o, e_we, e_ready, e_grant, e_busy, e_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_all_valid();
        test_full_stall();
        test_owner_drop();
        test_reset_midburst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
